// File: rtl/vector_store_unit_if.sv
// Bundle of the upstream request handshake and the byte-wide memory write port
// of the vector store unit, plus its status flags.
interface vector_store_unit_if #(
  parameter int BITS_ARRAY = 64,
  parameter int BITS_DATA  = 8,
  parameter int BITS_ADDR  = 16
);
  localparam int LANES = BITS_ARRAY / BITS_DATA;

  // Upstream: a request transfers on a rising edge where startValid && startReady.
  // Memory: a byte write completes on a rising edge where memWrite && memReady.
  logic                  startValid;
  logic                  startReady;
  logic [BITS_ADDR-1:0]  baseAddress;
  logic [BITS_ARRAY-1:0] vectorData;
  logic [LANES-1:0]      laneMask;
  logic                  memWrite;
  logic [BITS_ADDR-1:0]  memAddress;
  logic [BITS_DATA-1:0]  memData;
  logic                  memReady;
  logic                  busy;
  logic                  done;

  modport master (
    output startValid, baseAddress, vectorData, laneMask, memReady,
    input  startReady, memWrite, memAddress, memData, busy, done
  );

  modport slave (
    input  startValid, baseAddress, vectorData, laneMask, memReady,
    output startReady, memWrite, memAddress, memData, busy, done
  );
endinterface

// File: rtl/vector_store_unit.sv
// Sequential writeback: captures one packed lane vector and writes its masked
// lanes one byte per cycle to data memory, lane 0 first.
module vector_store_unit #(
  parameter int BITS_ARRAY = 64,
  parameter int BITS_DATA  = 8,
  parameter int BITS_ADDR  = 16
) (
  input  logic                clk,
  input  logic                reset,
  vector_store_unit_if.slave  bus,
  output logic [1:0]          dbg_state_o
);
  localparam int LANES  = BITS_ARRAY / BITS_DATA;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                state_q;
  logic [LANE_W-1:0]     lane_q;
  logic [BITS_ARRAY-1:0] data_q;
  logic [BITS_ADDR-1:0]  base_q;
  logic [LANES-1:0]      mask_q;

  logic                  start_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  mem_write_q;
  logic [BITS_ADDR-1:0]  mem_addr_q;
  logic [BITS_DATA-1:0]  mem_data_q;

  logic                  advance_d;
  logic                  last_lane_d;
  logic [LANE_W-1:0]     lane_d;

  // Masked-off lanes never wait for memory; unmasked lanes wait for memReady.
  always_comb begin
    advance_d   = !mask_q[lane_q] || bus.memReady;
    last_lane_d = (lane_q == LANE_W'(LANES - 1));
    lane_d      = lane_q + LANE_W'(1);
  end

  // The memory port is registered: each transition loads the view of the lane
  // that will be presented in the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      lane_q        <= '0;
      data_q        <= '0;
      base_q        <= '0;
      mask_q        <= '0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.startValid) begin
            state_q       <= ST_WRITE;
            lane_q        <= '0;
            data_q        <= bus.vectorData;
            base_q        <= bus.baseAddress;
            mask_q        <= bus.laneMask;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            mem_write_q   <= bus.laneMask[0];
            mem_addr_q    <= bus.baseAddress;
            mem_data_q    <= bus.vectorData[BITS_DATA-1:0];
          end
        end
        ST_WRITE: begin
          if (advance_d) begin
            if (last_lane_d) begin
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              mem_write_q <= 1'b0;
              mem_addr_q  <= '0;
              mem_data_q  <= '0;
            end else begin
              lane_q      <= lane_d;
              mem_write_q <= mask_q[lane_d];
              mem_addr_q  <= base_q + BITS_ADDR'(lane_d);
              mem_data_q  <= data_q[int'(lane_d) * BITS_DATA +: BITS_DATA];
            end
          end
        end
        ST_DONE: begin
          state_q       <= ST_IDLE;
          done_q        <= 1'b0;
          busy_q        <= 1'b0;
          start_ready_q <= 1'b1;
        end
        default: begin
          state_q       <= ST_IDLE;
          lane_q        <= '0;
          start_ready_q <= 1'b1;
          busy_q        <= 1'b0;
          done_q        <= 1'b0;
          mem_write_q   <= 1'b0;
          mem_addr_q    <= '0;
          mem_data_q    <= '0;
        end
      endcase
    end
  end

  assign bus.startReady = start_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.memWrite   = mem_write_q;
  assign bus.memAddress = mem_addr_q;
  assign bus.memData    = mem_data_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_vector_store_unit.sv
// Directed bench for vector_store_unit: expected memory writes are queued when a
// request is sent and popped by a monitor as the block issues them.
module tb_vector_store_unit;
  localparam int BA    = 64;
  localparam int BD    = 8;
  localparam int BADDR = 16;
  localparam int LANES = BA / BD;

  localparam logic [63:0] VEC_A = 64'h8877665544332211;
  localparam logic [63:0] VEC_B = 64'hF0E1D2C3B4A59687;
  localparam logic [63:0] VEC_C = 64'h0123456789ABCDEF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  vector_store_unit_if #(.BITS_ARRAY(BA), .BITS_DATA(BD), .BITS_ADDR(BADDR)) bus ();

  vector_store_unit #(.BITS_ARRAY(BA), .BITS_DATA(BD), .BITS_ADDR(BADDR)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  logic [23:0] exp_q[$];
  logic [23:0] mon_e;
  logic [7:0]  cur_mask;
  int          checks = 0;
  int          errors = 0;
  int          kd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every completing write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && bus.memWrite === 1'b1 && bus.memReady === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("extra_write", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write", {8'h00, bus.memAddress, bus.memData}, {8'h00, mon_e});
      end
    end
  end

  task automatic push_exp(input logic [15:0] base, input logic [63:0] vec, input logic [7:0] mask);
    logic [15:0] a;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        a = base + 16'(i);
        exp_q.push_back({a, vec[8*i +: 8]});
      end
    end
  endtask

  // Drives one request; returns at the start of cycle 1 (just after the accept edge).
  task automatic send(input logic [15:0] base, input logic [63:0] vec, input logic [7:0] mask,
                      input logic [7:0] keep);
    push_exp(base, vec, mask & keep);
    cur_mask = mask;
    @(posedge clk); #1;
    bus.startValid  = 1'b1;
    bus.baseAddress = base;
    bus.vectorData  = vec;
    bus.laneMask    = mask;
    @(posedge clk); #1;
    bus.startValid  = 1'b0;
  endtask

  // Walks cycles k0.. after acceptance; returns at the negedge where done is seen,
  // or at the start of cycle stop_at.
  task automatic run(input int k0, input int stall_start, input int stall_n,
                     input logic [15:0] stall_addr, input logic [7:0] stall_data,
                     input bit scramble, input int stop_at, output int k_done);
    int k;
    k = k0;
    k_done = -1;
    while (k <= 40) begin
      if (k == stop_at) begin
        k_done = k;
        return;
      end
      bus.memReady = !(k >= stall_start && k < stall_start + stall_n);
      if (scramble && k >= 2 && k <= 5) begin
        bus.startValid  = k[0];
        bus.baseAddress = 16'($urandom);
        bus.vectorData  = {$urandom, $urandom};
        bus.laneMask    = 8'($urandom_range(0, 255));
      end
      if (scramble && k == 6) bus.startValid = 1'b0;
      @(negedge clk);
      if (stall_n > 0 && k >= stall_start && k <= stall_start + stall_n) begin
        chk("stall_addr", 32'(bus.memAddress), 32'(stall_addr));
        chk("stall_data", 32'(bus.memData), 32'(stall_data));
      end
      if (stall_n == 0 && k >= 1 && k <= LANES)
        chk("mem_write_lane", 32'(bus.memWrite), 32'(cur_mask[k-1]));
      if (bus.done === 1'b1) begin
        k_done = k;
        return;
      end
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic post_done();
    @(posedge clk);
    @(negedge clk);
    chk("idle_start_ready", 32'(bus.startReady), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_mem_write", 32'(bus.memWrite), 32'd0);
    chk("idle_mem_addr", 32'(bus.memAddress), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.startValid  = 1'b0;
    bus.baseAddress = '0;
    bus.vectorData  = '0;
    bus.laneMask    = '0;
    bus.memReady    = 1'b1;
    cur_mask        = '0;
    reset           = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_start_ready", 32'(bus.startReady), 32'd1);
    chk("rst_mem_write", 32'(bus.memWrite), 32'd0);
    chk("rst_mem_addr", 32'(bus.memAddress), 32'd0);
    chk("rst_mem_data", 32'(bus.memData), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);

    // Basic store, all lanes.
    send(16'h0100, VEC_A, 8'hFF, 8'hFF);
    run(1, 0, 0, 16'h0, 8'h0, 1'b0, -1, kd);
    chk("basic_done_cycle", 32'(kd), 32'd9);
    post_done();

    // Masked lanes 0,2,5,7.
    send(16'h0100, VEC_A, 8'b10100101, 8'hFF);
    run(1, 0, 0, 16'h0, 8'h0, 1'b0, -1, kd);
    chk("masked_done_cycle", 32'(kd), 32'd9);
    post_done();

    // Three cycles of backpressure on lane 2.
    send(16'h0100, VEC_A, 8'hFF, 8'hFF);
    run(1, 3, 3, 16'h0102, 8'h33, 1'b0, -1, kd);
    chk("stall_done_cycle", 32'(kd), 32'd12);
    post_done();

    // Address wrap past 0xFFFF.
    send(16'hFFFD, VEC_B, 8'hFF, 8'hFF);
    run(1, 0, 0, 16'h0, 8'h0, 1'b0, -1, kd);
    chk("wrap_done_cycle", 32'(kd), 32'd9);
    post_done();

    // Upstream activity during WRITE must not disturb the captured request.
    send(16'h2000, VEC_C, 8'h5A, 8'hFF);
    run(1, 0, 0, 16'h0, 8'h0, 1'b1, -1, kd);
    chk("iso_done_cycle", 32'(kd), 32'd9);

    // New request presented while done=1: taken only on the following IDLE cycle.
    bus.startValid  = 1'b1;
    bus.baseAddress = 16'h3000;
    bus.vectorData  = VEC_B;
    bus.laneMask    = 8'hFF;
    push_exp(16'h3000, VEC_B, 8'hFF);
    cur_mask = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    chk("ovl_not_taken_busy", 32'(bus.busy), 32'd0);
    chk("ovl_start_ready", 32'(bus.startReady), 32'd1);
    @(posedge clk); #1;
    bus.startValid = 1'b0;
    @(negedge clk);
    chk("ovl_taken_busy", 32'(bus.busy), 32'd1);
    chk("ovl_lane0_addr", 32'(bus.memAddress), 32'h3000);
    @(posedge clk); #1;
    run(2, 0, 0, 16'h0, 8'h0, 1'b0, -1, kd);
    chk("ovl_done_cycle", 32'(kd), 32'd9);
    post_done();

    // Reset while lane 4 is presented (held off by memReady=0).
    send(16'h4000, VEC_A, 8'hFF, 8'h0F);
    run(1, 0, 0, 16'h0, 8'h0, 1'b0, 5, kd);
    bus.memReady = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    chk("pre_rst_lane4_addr", 32'(bus.memAddress), 32'h4004);
    @(posedge clk); #1;
    reset        = 1'b0;
    bus.memReady = 1'b1;
    @(negedge clk);
    chk("mid_rst_mem_write", 32'(bus.memWrite), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_start_ready", 32'(bus.startReady), 32'd1);
    repeat (10) @(negedge clk);
    chk("mid_rst_queue", 32'(exp_q.size()), 32'd0);

    send(16'h5000, VEC_C, 8'h81, 8'hFF);
    run(1, 0, 0, 16'h0, 8'h0, 1'b0, -1, kd);
    chk("after_rst_done_cycle", 32'(kd), 32'd9);
    post_done();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
